// File: rtl/rule_split_1t2.sv
// rule_split_1t2: steers a rule stream onto two deduplicating lane FIFOs and broadcasts
// each end-of-packet marker (the MSB of the rule) to both lanes.
module rule_split_1t2 #(
   parameter int RULE_S_WIDTH = 16,
   parameter int STEER_BIT    = 0,
   parameter int LANE_DEPTH   = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [RULE_S_WIDTH-1:0] in_data,
   input  logic                    in_valid,
   output logic                    in_ready,
   output logic [RULE_S_WIDTH-1:0] out_data_0,
   output logic                    out_valid_0,
   input  logic                    out_ready_0,
   output logic [RULE_S_WIDTH-1:0] out_data_1,
   output logic                    out_valid_1,
   input  logic                    out_ready_1,
   output logic [31:0]             stat_pkt_cnt,
   output logic [31:0]             stat_dup_cnt
);
   localparam logic [0:0] RUN   = 1'b0;
   localparam logic [0:0] BCAST = 1'b1;
   logic [0:0] state;
   logic [1:0] pend, space, push;
   logic [RULE_S_WIDTH-1:0] last_reg, cache_0, cache_1, push_data;
   logic cache_valid_0, cache_valid_1, lane, is_last, dup, accept;

   assign lane      = in_data[STEER_BIT];
   assign is_last   = in_data[RULE_S_WIDTH-1];
   assign dup       = !is_last && (lane ? cache_valid_1 && in_data == cache_1
                                        : cache_valid_0 && in_data == cache_0);
   assign in_ready  = rst_n && state == RUN && (is_last || dup || space[lane]);
   assign accept    = in_valid && in_ready;
   assign push_data = state == RUN ? in_data : last_reg;

   always_comb begin
      push[0] = state == RUN ? accept && !dup && (is_last ? space[0] : !lane) : pend[0] && space[0];
      push[1] = state == RUN ? accept && !dup && (is_last ? space[1] : lane)  : pend[1] && space[1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= RUN;
         pend          <= 2'b00;
         last_reg      <= '0;
         cache_0       <= '0;
         cache_1       <= '0;
         cache_valid_0 <= 1'b0;
         cache_valid_1 <= 1'b0;
         stat_pkt_cnt  <= 32'd0;
         stat_dup_cnt  <= 32'd0;
      end else if (state == RUN) begin
         if (accept && is_last) begin
            last_reg      <= in_data;
            pend          <= ~space;
            cache_0       <= '0;
            cache_1       <= '0;
            cache_valid_0 <= 1'b0;
            cache_valid_1 <= 1'b0;
            state         <= space == 2'b11 ? RUN : BCAST;
            if (space == 2'b11) stat_pkt_cnt <= stat_pkt_cnt + 32'd1;
         end else if (accept && dup) begin
            stat_dup_cnt <= stat_dup_cnt + 32'd1;
         end else if (accept && lane) begin
            cache_1       <= in_data;
            cache_valid_1 <= 1'b1;
         end else if (accept) begin
            cache_0       <= in_data;
            cache_valid_0 <= 1'b1;
         end
      end else begin
         pend <= pend & ~push;
         if ((pend & ~push) == 2'b00) begin
            state        <= RUN;
            stat_pkt_cnt <= stat_pkt_cnt + 32'd1;
         end
      end
   end

   rule_split_fifo #(.W(RULE_S_WIDTH), .DEPTH(LANE_DEPTH)) u_lane_0 (
      .clk(clk), .rst_n(rst_n), .push(push[0]), .data_in(push_data), .ready(out_ready_0),
      .data_out(out_data_0), .valid(out_valid_0), .space(space[0])
   );
   rule_split_fifo #(.W(RULE_S_WIDTH), .DEPTH(LANE_DEPTH)) u_lane_1 (
      .clk(clk), .rst_n(rst_n), .push(push[1]), .data_in(push_data), .ready(out_ready_1),
      .data_out(out_data_1), .valid(out_valid_1), .space(space[1])
   );
endmodule

// rule_split_fifo: lane FIFO; space reflects the registered count only, so a pop never
// frees room for a push in the same cycle.
module rule_split_fifo #(
   parameter int W     = 16,
   parameter int DEPTH = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic [W-1:0] data_in,
   input  logic         ready,
   output logic [W-1:0] data_out,
   output logic         valid,
   output logic         space
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
   logic [W-1:0] mem [DEPTH];
   logic [AW-1:0] wr, rd;
   logic [AW:0] cnt;
   logic pop;

   assign valid    = cnt != '0;
   assign space    = cnt != FULL;
   assign pop      = ready && valid;
   assign data_out = valid ? mem[rd] : '0;

   always_ff @(posedge clk) if (push) mem[wr] <= data_in;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr  <= '0;
         rd  <= '0;
         cnt <= '0;
      end else begin
         if (push) wr <= wr + AW'(1);
         if (pop) rd <= rd + AW'(1);
         cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
      end
   end
endmodule

// File: tb/tb_rule_split_1t2.sv
// tb_rule_split_1t2: directed stimulus with per-lane expected queues checked by a
// monitor whenever a lane hands a rule downstream.
module tb_rule_split_1t2;
   localparam int W = 16;
   localparam int D = 4;
   localparam logic [W-1:0] A = 16'h0010, B = 16'h0021, L = 16'h8000;

   logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, in_ready;
   logic [W-1:0] in_data = '0, out_data_0, out_data_1;
   logic out_valid_0, out_valid_1, out_ready_0 = 1'b0, out_ready_1 = 1'b0;
   logic [31:0] stat_pkt_cnt, stat_dup_cnt;
   logic [W-1:0] q0[$], q1[$];
   int checks = 0, errors = 0;

   always #5 clk = ~clk;

   rule_split_1t2 #(.RULE_S_WIDTH(W), .STEER_BIT(0), .LANE_DEPTH(D)) dut (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data_0(out_data_0), .out_valid_0(out_valid_0), .out_ready_0(out_ready_0),
      .out_data_1(out_data_1), .out_valid_1(out_valid_1), .out_ready_1(out_ready_1),
      .stat_pkt_cnt(stat_pkt_cnt), .stat_dup_cnt(stat_dup_cnt)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // handshakes complete on the following rising edge
   always @(negedge clk) begin
      if (rst_n && out_valid_0 && out_ready_0) begin
         if (q0.size() == 0) chk("lane0 unexpected", 32'(out_data_0), 32'hffff_ffff);
         else chk("lane0 data", 32'(out_data_0), 32'(q0.pop_front()));
      end
      if (rst_n && out_valid_1 && out_ready_1) begin
         if (q1.size() == 0) chk("lane1 unexpected", 32'(out_data_1), 32'hffff_ffff);
         else chk("lane1 data", 32'(out_data_1), 32'(q1.pop_front()));
      end
   end

   task automatic send(input logic [W-1:0] d);
      int n = 0;
      in_data  = d;
      in_valid = 1'b1;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         if (++n > 200) begin
            chk("send timeout", 32'(in_ready), 32'd1);
            break;
         end
      end
      @(posedge clk) #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((q0.size() != 0 || q1.size() != 0) && n < 100) begin
         @(posedge clk);
         n++;
      end
      repeat (2) @(posedge clk);
      #1 chk("drain", 32'(q0.size() + q1.size()), 32'd0);
   endtask

   initial begin
      in_data = A;
      #12;
      chk("rst in_ready", 32'(in_ready), 32'd0);
      chk("rst valids", {30'd0, out_valid_1, out_valid_0}, 32'd0);
      chk("rst data0", 32'(out_data_0), 32'd0);
      chk("rst pkt", stat_pkt_cnt, 32'd0);
      chk("rst dup", stat_dup_cnt, 32'd0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk) #1;
      out_ready_0 = 1'b1;
      out_ready_1 = 1'b1;
      // basic steering and broadcast
      q0.push_back(A);
      send(A);
      chk("latency valid0", 32'(out_valid_0), 32'd1);
      chk("latency data0", 32'(out_data_0), 32'(A));
      q1.push_back(B);
      send(B);
      q0.push_back(L); q1.push_back(L);
      send(L);
      drain();
      chk("t1 pkt", stat_pkt_cnt, 32'd1);
      // duplicate suppression, cache cleared by last
      q0.push_back(A);
      send(A); send(A); send(A);
      q0.push_back(L); q1.push_back(L);
      send(L);
      q0.push_back(A);
      send(A);
      q0.push_back(L); q1.push_back(L);
      send(L);
      drain();
      chk("t2 dup", stat_dup_cnt, 32'd2);
      chk("t2 pkt", stat_pkt_cnt, 32'd3);
      // lane 1 full when last arrives
      out_ready_1 = 1'b0;
      for (int i = 0; i < D; i++) begin
         q1.push_back(W'(16'h0101 + 2 * i));
         send(W'(16'h0101 + 2 * i));
      end
      q0.push_back(L); q1.push_back(L);
      send(L);
      in_data = A;
      #1 chk("t3 bcast in_ready", 32'(in_ready), 32'd0);
      chk("t3 pkt held", stat_pkt_cnt, 32'd3);
      @(posedge clk) #1 out_ready_1 = 1'b1;
      @(posedge clk) #1 out_ready_1 = 1'b0;
      @(posedge clk) #1;
      chk("t3 run in_ready", 32'(in_ready), 32'd1);
      chk("t3 pkt", stat_pkt_cnt, 32'd4);
      out_ready_1 = 1'b1;
      drain();
      // lane 0 full blocks input
      out_ready_0 = 1'b0;
      for (int i = 0; i < D; i++) begin
         q0.push_back(W'(16'h0200 + 2 * i));
         send(W'(16'h0200 + 2 * i));
      end
      q0.push_back(16'h0208);
      in_data  = 16'h0208;
      in_valid = 1'b1;
      @(negedge clk) chk("t4 full in_ready", 32'(in_ready), 32'd0);
      chk("t4 head held", 32'(out_data_0), 32'h0200);
      @(posedge clk) #1 out_ready_0 = 1'b1;
      @(negedge clk) chk("t4 pop no space", 32'(in_ready), 32'd0);
      @(posedge clk) #1 out_ready_0 = 1'b0;
      @(negedge clk) chk("t4 after pop", 32'(in_ready), 32'd1);
      @(posedge clk) #1 in_valid = 1'b0;
      q1.push_back(16'h0301);
      send(16'h0301);
      out_ready_0 = 1'b1;
      q0.push_back(L); q1.push_back(L);
      send(L);
      drain();
      chk("t4 pkt", stat_pkt_cnt, 32'd5);
      // reset while broadcasting with lane 1 pending
      out_ready_0 = 1'b0;
      out_ready_1 = 1'b0;
      for (int i = 0; i < D; i++) send(W'(16'h0401 + 2 * i));
      send(L);
      in_data = A;
      chk("t5 bcast valids", {30'd0, out_valid_1, out_valid_0}, 32'd3);
      chk("t5 bcast in_ready", 32'(in_ready), 32'd0);
      #2 rst_n = 1'b0;
      #1 chk("t5 async valids", {30'd0, out_valid_1, out_valid_0}, 32'd0);
      chk("t5 rst in_ready", 32'(in_ready), 32'd0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk) #1;
      chk("t5 in_ready", 32'(in_ready), 32'd1);
      chk("t5 pkt", stat_pkt_cnt, 32'd0);
      chk("t5 dup", stat_dup_cnt, 32'd0);
      out_ready_0 = 1'b1;
      out_ready_1 = 1'b1;
      q0.push_back(A);
      send(A);
      q0.push_back(L); q1.push_back(L);
      send(L);
      drain();
      chk("t5 pkt after", stat_pkt_cnt, 32'd1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
